// File: rtl/tinysimt_pkg.sv
// tinysimt_pkg: shared constants and packed-array helpers for the TinySIMT core array
package tinysimt_pkg;
  localparam int NUM_CORES = 4;
  localparam int BOFF = 2;
  function automatic int lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: core-side request/response bus of the shared data SRAM arbiter
interface mem_arbiter_rr_if #(parameter int N = 4, parameter int AW = 32);
  logic [N-1:0] req;
  logic [N-1:0] we;
  logic [N*AW-1:0] addr;
  logic [N*32-1:0] wdata;
  logic [N-1:0] stall;
  logic [N*32-1:0] rdata;
  modport master(output req, we, addr, wdata, input stall, rdata);
  modport slave(input req, we, addr, wdata, output stall, rdata);
endinterface

// File: rtl/mem_arbiter_rr_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or cyclically after ptr
module rr_pick #(parameter int N = 4, parameter int PW = $clog2(N)) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx
);
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[ptr + PW'(k)]) begin
        win = N'(1) << (ptr + PW'(k));
        idx = ptr + PW'(k);
      end
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one data SRAM among N cores, with read coalescing
import tinysimt_pkg::*;
module mem_arbiter_rr #(
  parameter int N = NUM_CORES,
  parameter int AW = 32,
  parameter int CW = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_arbiter_rr_if.slave     bus,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_we,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                cnt_clear,
  output logic [N*CW-1:0]     stall_cnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, widx;
  logic [N-1:0] win, g;
  logic [AW-1:0] aw;
  logic any;
  logic [CW-1:0] cnt [N];
  assign any = |bus.req;
  rr_pick #(.N(N)) u_pick (.req(bus.req), .ptr(ptr), .win(win), .idx(widx));
  assign aw = bus.addr[lo(int'(widx), AW) +: AW];
  // A reading winner pulls in every other reader of the same word; a storing winner goes alone
  always_comb begin
    g = win;
    for (int j = 0; j < N; j++)
      if (!bus.we[widx] && bus.req[j] && !bus.we[j] &&
          bus.addr[lo(j, AW) + BOFF +: AW - BOFF] == aw[AW-1:BOFF])
        g[j] = 1'b1;
  end
  assign bus.stall = reset ? '1 : bus.req & ~g;
  assign bus.rdata = reset ? '0 : {N{mem_rdata}};
  assign mem_we = ~reset & any & bus.we[widx];
  assign mem_addr = (reset | ~any) ? '0 : aw;
  assign mem_wdata = (reset | ~any) ? '0 : bus.wdata[lo(int'(widx), 32) +: 32];
  always_ff @(posedge clk) begin
    ptr <= reset ? '0 : any ? widx + PW'(1) : ptr;
    for (int i = 0; i < N; i++)
      cnt[i] <= (reset || cnt_clear) ? '0 : (bus.stall[i] && ~&cnt[i]) ? cnt[i] + CW'(1) : cnt[i];
  end
  for (genvar i = 0; i < N; i++) begin : g_cnt
    assign stall_cnt[i*CW +: CW] = cnt[i];
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: scoreboard bench comparing the arbiter to a queue-based reference model
module tb_mem_arbiter_rr;
  localparam int N = 4, AW = 32, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset = 1, cnt_clear = 0;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [N*CW-1:0] stall_cnt;
  logic [31:0] sram [128];
  mem_arbiter_rr_if #(.N(N), .AW(AW)) bus ();
  mem_arbiter_rr #(.N(N), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cnt_clear(cnt_clear), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  assign mem_rdata = sram[mem_addr[8:2]];
  always @(posedge clk) if (mem_we) sram[mem_addr[8:2]] <= mem_wdata;

  typedef struct {
    logic [N-1:0] stall, rd;
    logic we;
    logic [31:0] addr, wdata, rdata;
    logic [N*CW-1:0] cnt;
    int cyc;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, steps = 0;
  int m_ptr = 0;
  int m_cnt [N];
  logic [31:0] m_mem [128];
  logic [31:0] ta [N];
  logic [31:0] td [N];

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", e.cyc, 64'(bus.stall), 64'(e.stall));
      chk("mem_we", e.cyc, 64'(mem_we), 64'(e.we));
      chk("mem_addr", e.cyc, 64'(mem_addr), 64'(e.addr));
      chk("mem_wdata", e.cyc, 64'(mem_wdata), 64'(e.wdata));
      chk("stall_cnt", e.cyc, 64'(stall_cnt), 64'(e.cnt));
      for (int i = 0; i < N; i++)
        if (e.rd[i]) chk($sformatf("rdata%0d", i), e.cyc, 64'(bus.rdata[i*32 +: 32]), 64'(e.rdata));
    end
  end

  task automatic step(input logic rs, input logic cl, input logic [N-1:0] r, input logic [N-1:0] w,
                      output logic [N-1:0] st);
    exp_t e;
    int win;
    logic [N-1:0] g;
    @(posedge clk);
    #1;
    reset = rs;
    cnt_clear = cl;
    bus.req = r;
    bus.we = w;
    for (int i = 0; i < N; i++) begin
      bus.addr[i*AW +: AW] = ta[i];
      bus.wdata[i*32 +: 32] = td[i];
      e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    e.cyc = steps++;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    g = '0;
    if (win >= 0) begin
      g[win] = 1'b1;
      if (!w[win])
        for (int j = 0; j < N; j++)
          if (r[j] && !w[j] && ta[j][31:2] == ta[win][31:2]) g[j] = 1'b1;
    end
    if (rs) begin
      e.stall = '1; e.we = 0; e.addr = 0; e.wdata = 0; e.rd = '1; e.rdata = 0;
    end else begin
      e.stall = r & ~g;
      e.we = (win >= 0) && w[win];
      e.addr = (win >= 0) ? ta[win] : 0;
      e.wdata = (win >= 0) ? td[win] : 0;
      e.rd = g & ~w;
      e.rdata = (win >= 0) ? m_mem[ta[win][8:2]] : 0;
    end
    q.push_back(e);
    st = e.stall;
    if (rs) begin
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        if (w[win]) m_mem[ta[win][8:2]] = td[win];
      end
      for (int i = 0; i < N; i++)
        m_cnt[i] = cl ? 0 : (e.stall[i] && m_cnt[i] < CMAX) ? m_cnt[i] + 1 : m_cnt[i];
    end
  endtask

  task automatic set_a(input logic [31:0] a0, a1, a2, a3);
    ta[0] = a0; ta[1] = a1; ta[2] = a2; ta[3] = a3;
  endtask

  initial begin
    logic [N-1:0] st, p;
    int guard;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    for (int k = 0; k < 128; k++) begin
      sram[k] = 32'h1000_0000 + k * 32'h0101;
      m_mem[k] = sram[k];
    end
    sram[32'h40] = 32'hDEADBEEF;
    m_mem[32'h40] = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; ta[i] = 0; td[i] = $urandom;
    end
    step(1, 0, '0, '0, st);
    repeat (3) step(0, 0, '0, '0, st);
    set_a(32'h0, 32'h4, 32'h8, 32'hC);
    p = '1; guard = 0;
    while (p != 0 && guard++ < 8) begin step(0, 0, p, '1, st); p = st; end
    set_a(32'h100, 32'h100, 32'h102, 32'h103);
    step(0, 0, '1, '0, st);
    step(0, 0, 4'b0001, '0, st);
    step(1, 0, '0, '0, st);
    set_a(32'h10, 32'h10, 32'h10, 32'h0);
    td[0] = 32'h12345678;
    p = 4'b0111; guard = 0;
    while (p != 0 && guard++ < 8) begin step(0, 0, p, 4'b0001 & p, st); p = st; end
    step(1, 0, '0, '0, st);
    set_a(32'h20, 32'h24, 32'h28, 32'h2C);
    step(0, 0, 4'b0001, '0, st);
    p = 4'b1000;
    repeat (3) begin step(0, 0, 4'b0010 | p, '0, st); p = st & 4'b1000; end
    step(1, 0, '0, '0, st);
    repeat (40) step(0, 0, '1, '1, st);
    step(0, 1, '1, '1, st);
    step(0, 0, '1, '1, st);
    step(1, 0, '1, '1, st);
    step(0, 0, '1, '1, st);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = 32'h100 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
        td[i] = $urandom;
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, N'($urandom), N'($urandom), st);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
